mem_mmio_responder: RTL and testbench



---
 rtl/mem_mmio_responder.sv | 172 +++++++++++++++++
 tb/tb_mem_mmio_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mmio_responder.sv
// Bus responder for the core's memory port: word RAM, LED register and cycle timer.
// Sub-word RAM stores complete as a two-cycle read-modify-write.
module mem_mmio_responder #(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] LED_ADDR   = 32'h0000_00A0,
  parameter logic [31:0] TIMER_ADDR = 32'h0000_00A4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic [3:0]  leds
);
  localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  typedef enum logic [0:0] {IDLE = 1'b0, RMW = 1'b1} state_t;

  state_t         state_r, state_next_s;
  logic [31:0]    mem_r [MEM_WORDS];
  logic [31:0]    timer_r, timer_next_s;
  logic [3:0]     leds_r, leds_next_s;
  logic           rvalid_r, rvalid_next_s;
  logic           err_r, err_next_s;
  logic [31:0]    rdata_r, rdata_next_s;
  logic [AW-1:0]  rmw_idx_r;
  logic [1:0]     rmw_lane_r, rmw_size_r;
  logic [31:0]    rmw_wdata_r;
  logic           latch_en_s, timer_we_s, mem_we_s;
  logic [AW-1:0]  mem_widx_s, rd_idx_s;
  logic [31:0]    mem_wword_s, rd_word_s, mmio_word_s, mmio_merged_s;
  logic           misaligned_s, hit_led_s, hit_tmr_s, hit_ram_s;

  // Overlay the addressed byte/half lane of wd onto old_word; word sizes replace it.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word, input logic [31:0] wd,
                                             input logic [1:0] lane, input logic [1:0] sz);
    logic [31:0] m;
    m = old_word;
    case (sz)
      2'd0:    m[{lane, 3'b000} +: 8]      = wd[7:0];
      2'd1:    m[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] sz);
    logic [31:0] s;
    s = word >> {lane, 3'b000};
    case (sz)
      2'd0:    return {24'h00_0000, s[7:0]};
      2'd1:    return {16'h0000, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign misaligned_s  = (size == 2'd1) ? addr[0] : (size[1] ? (addr[1:0] != 2'b00) : 1'b0);
  assign hit_led_s     = (addr[31:2] == LED_ADDR[31:2]);
  assign hit_tmr_s     = (addr[31:2] == TIMER_ADDR[31:2]);
  assign hit_ram_s     = !hit_led_s && !hit_tmr_s && (addr[31:2] < MEM_WORDS_W);
  assign rd_idx_s      = (state_r == RMW) ? rmw_idx_r : addr[AW+1:2];
  assign rd_word_s     = mem_r[rd_idx_s];
  assign mmio_word_s   = hit_led_s ? {28'h000_0000, leds_r} : timer_r;
  assign mmio_merged_s = merge_lane(mmio_word_s, wdata, addr[1:0], size);

  assign busy   = (state_r == RMW);
  assign rvalid = rvalid_r;
  assign err    = err_r;
  assign rdata  = rdata_r;
  assign leds   = leds_r;

  // Next-state, response and write-port decode.
  always_comb begin
    state_next_s  = state_r;
    rvalid_next_s = 1'b0;
    err_next_s    = 1'b0;
    rdata_next_s  = 32'h0000_0000;
    leds_next_s   = leds_r;
    timer_we_s    = 1'b0;
    timer_next_s  = mmio_merged_s;
    latch_en_s    = 1'b0;
    mem_we_s      = 1'b0;
    mem_widx_s    = addr[AW+1:2];
    mem_wword_s   = wdata;
    case (state_r)
      IDLE: begin
        if (req) begin
          if (misaligned_s) begin
            err_next_s = 1'b1;
          end else if (we) begin
            if (hit_led_s) begin
              leds_next_s = mmio_merged_s[3:0];
            end else if (hit_tmr_s) begin
              timer_we_s = 1'b1;
            end else if (hit_ram_s) begin
              if (size[1]) begin
                mem_we_s = 1'b1;
              end else begin
                latch_en_s   = 1'b1;
                state_next_s = RMW;
              end
            end else begin
              mem_we_s = 1'b0;
            end
          end else begin
            rvalid_next_s = 1'b1;
            if (hit_led_s || hit_tmr_s) begin
              rdata_next_s = extract_lane(mmio_word_s, addr[1:0], size);
            end else if (hit_ram_s) begin
              rdata_next_s = extract_lane(rd_word_s, addr[1:0], size);
            end else begin
              rdata_next_s = 32'h0000_0000;
            end
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RMW: begin
        mem_we_s     = 1'b1;
        mem_widx_s   = rmw_idx_r;
        mem_wword_s  = merge_lane(rd_word_s, rmw_wdata_r, rmw_lane_r, rmw_size_r);
        state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Control, response and MMIO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rvalid_r    <= 1'b0;
      err_r       <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      leds_r      <= 4'h0;
      timer_r     <= 32'h0000_0000;
      rmw_idx_r   <= '0;
      rmw_lane_r  <= 2'b00;
      rmw_size_r  <= 2'b00;
      rmw_wdata_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_next_s;
      rvalid_r <= rvalid_next_s;
      err_r    <= err_next_s;
      rdata_r  <= rdata_next_s;
      leds_r   <= leds_next_s;
      timer_r  <= timer_we_s ? timer_next_s : timer_r + 32'd1;
      if (latch_en_s) begin
        rmw_idx_r   <= addr[AW+1:2];
        rmw_lane_r  <= addr[1:0];
        rmw_size_r  <= size;
        rmw_wdata_r <= wdata;
      end
    end
  end

  // RAM write port; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[mem_widx_s] <= mem_wword_s;
    end
  end
endmodule

// File: tb/tb_mem_mmio_responder.sv
// Scoreboard bench for mem_mmio_responder: reference model predicts responses,
// a negedge monitor pops and compares them.
module tb_mem_mmio_responder;
  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        busy, rvalid, err;
  logic [31:0] rdata;
  logic [3:0]  leds;

  mem_mmio_responder #(.MEM_WORDS(MEM_WORDS), .LED_ADDR(32'h0000_00A0), .TIMER_ADDR(32'h0000_00A4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size), .wdata(wdata),
    .busy(busy), .rvalid(rvalid), .rdata(rdata), .err(err), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_err; logic [31:0] data; } exp_t;
  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state (value during the current cycle) and writes pending at the next edge
  logic [31:0] m_mem [int];
  logic [3:0]  m_leds;
  logic [31:0] m_tm;
  bit          m_busy;
  bit          p_we, p_lwe, p_tstore, rmw_armed;
  int          p_idx;
  logic [31:0] p_word, p_tval;
  logic [3:0]  p_led;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] word, input int lane, input int n);
    logic [31:0] s;
    s = word >> (8 * lane);
    if (n == 4) return s;
    return s & ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old_word, input logic [31:0] wd,
                                          input int lane, input int n);
    logic [31:0] m;
    m = old_word;
    for (int b = 0; b < n; b++) m[8*(lane+b) +: 8] = wd[8*b +: 8];
    return m;
  endfunction

  // Advance one clock edge in DUT and model, then check busy and leds.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_tm = 32'd0; m_leds = 4'd0; m_busy = 1'b0;
      p_we = 1'b0; p_lwe = 1'b0; p_tstore = 1'b0; rmw_armed = 1'b0;
    end else begin
      if (p_we) m_mem[p_idx] = p_word;
      if (p_lwe) m_leds = p_led;
      m_tm = p_tstore ? p_tval : m_tm + 32'd1;
      m_busy = rmw_armed;
      p_we = rmw_armed;
      rmw_armed = 1'b0; p_lwe = 1'b0; p_tstore = 1'b0;
    end
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("leds", {28'd0, leds}, {28'd0, m_leds});
  endtask

  // Present one request in a non-busy cycle and predict its effect.
  task automatic issue(input bit w, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int lane, n, widx;
    bit mis, is_led, is_tmr, is_ram;
    logic [31:0] cur, mrg;
    exp_t e;
    req = 1'b1; we = w; addr = a; size = sz; wdata = wd;
    lane = int'(a[1:0]);
    n = nbytes(sz);
    mis = (n == 2 && a[0]) || (n == 4 && lane != 0);
    widx = int'(a >> 2);
    is_led = (a >> 2) == (32'h0000_00A0 >> 2);
    is_tmr = (a >> 2) == (32'h0000_00A4 >> 2);
    is_ram = !is_led && !is_tmr && ((a >> 2) < 32'(MEM_WORDS));
    cur = is_led ? {28'd0, m_leds} : (is_tmr ? m_tm : (is_ram ? m_mem[widx] : 32'd0));
    if (mis) begin
      e.is_err = 1'b1; e.data = 32'd0; sb_q.push_back(e);
    end else if (!w) begin
      e.is_err = 1'b0; e.data = m_extract(cur, lane, n); sb_q.push_back(e);
    end else begin
      mrg = m_merge(cur, wd, lane, n);
      if (is_led) begin
        p_lwe = 1'b1; p_led = mrg[3:0];
      end else if (is_tmr) begin
        p_tstore = 1'b1; p_tval = mrg;
      end else if (is_ram) begin
        p_idx = widx; p_word = mrg;
        if (n == 4) p_we = 1'b1;
        else rmw_armed = 1'b1;
      end
    end
    tick();
  endtask

  task automatic idle();
    req = 1'b0;
    tick();
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rvalid === 1'b1 || err === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_response rvalid=%b err=%b rdata=%h required=none", rvalid, err, rdata);
      end else begin
        e = sb_q.pop_front();
        if (e.is_err) begin
          chk("err_flags", {30'd0, rvalid, err}, 32'd1);
          chk("err_rdata", rdata, 32'd0);
        end else begin
          chk("load_flags", {30'd0, rvalid, err}, 32'd2);
          chk("load_rdata", rdata, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; size = 2'd0; wdata = 32'd0;
    m_tm = 32'd0; m_leds = 4'd0; m_busy = 1'b0;
    p_we = 1'b0; p_lwe = 1'b0; p_tstore = 1'b0; rmw_armed = 1'b0;
    p_idx = 0; p_word = 32'd0; p_tval = 32'd0; p_led = 4'd0;
    repeat (3) tick();
    chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    reset = 1'b0;

    // Word write/read, then byte RMW and sub-word readback
    issue(1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF);
    issue(1'b0, 32'h10, 2'd2, 32'd0);
    issue(1'b1, 32'h12, 2'd0, 32'h55);
    idle();
    issue(1'b0, 32'h10, 2'd2, 32'd0);
    issue(1'b0, 32'h12, 2'd1, 32'd0);
    issue(1'b0, 32'h13, 2'd0, 32'd0);

    // Misalignment leaves memory untouched
    issue(1'b0, 32'h11, 2'd2, 32'd0);
    issue(1'b1, 32'h13, 2'd1, 32'hFFFF_FFFF);
    issue(1'b0, 32'h10, 2'd2, 32'd0);

    // MMIO: LEDs and timer wrap
    issue(1'b1, 32'hA0, 2'd2, 32'h0000_000A);
    chk("leds_after_store", {28'd0, leds}, 32'h0000_000A);
    issue(1'b0, 32'hA0, 2'd2, 32'd0);
    issue(1'b1, 32'hA4, 2'd2, 32'hFFFF_FFFE);
    repeat (4) issue(1'b0, 32'hA4, 2'd2, 32'd0);

    // Reset during the busy cycle abandons the write
    issue(1'b1, 32'h10, 2'd0, 32'h00);
    reset = 1'b1; req = 1'b0;
    tick();
    chk("rst_rmw_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rmw_err", {31'd0, err}, 32'd0);
    chk("rst_rmw_rdata", rdata, 32'd0);
    reset = 1'b0;
    issue(1'b0, 32'h10, 2'd2, 32'd0);

    // Unmapped load, and a request held through the busy cycle
    issue(1'b0, 32'(MEM_WORDS * 4), 2'd2, 32'd0);
    issue(1'b1, 32'h11, 2'd0, 32'hA5);
    req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'd2;
    tick();
    issue(1'b0, 32'h10, 2'd2, 32'd0);

    // Fill the word range used by random traffic
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 2'd2, $urandom);
    issue(1'b1, 32'((MEM_WORDS - 1) * 4), 2'd2, $urandom);

    for (int i = 0; i < 600; i++) begin
      if (m_busy) begin
        req = 1'($urandom); we = 1'($urandom); addr = $urandom; size = 2'($urandom); wdata = $urandom;
        tick();
      end else begin
        int k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        case (k)
          6: a = 32'hA0;
          7: a = 32'hA4;
          8: a = 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 255) * 4);
          9: a = 32'((MEM_WORDS - 1) * 4);
          default: a = 32'($urandom_range(0, 15) * 4);
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) idle();
        else issue(1'($urandom), a, 2'($urandom_range(0, 3)), $urandom);
      end
    end

    req = 1'b0;
    repeat (3) idle();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
